// File: rtl/freq_div_prog.sv
// Multi-channel programmable clock divider.
// Each channel counts 0..div and produces either a 50% duty divided clock
// (square mode) or a one-cycle enable pulse (tick mode). Divisor and mode
// writes to a running channel go to a shadow register and take effect at
// that channel's next terminal count, so the outputs never glitch.
module freq_div_prog #(
  parameter int CNT_W    = 26,
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2,
  parameter int DEF_DIV  = 20000,
  parameter int DEF_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_TICK   = 1'b1
  } mode_t;

  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEF_DIV);
  localparam mode_t            RST_MODE = (DEF_MODE != 0) ? MODE_TICK : MODE_SQUARE;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] sh_div;
    mode_t            mode;
    mode_t            sh_mode;
    logic             clk_q;
    logic             tick_q;
    logic             pend_q;
    logic             wr;
    logic             term;

    // Writes addressed beyond NUM_CH match no channel and are dropped.
    assign wr   = cfg_we && (cfg_ch == CH_W'(i));
    assign term = (cnt == div);

    // Channel state: priority is reset, disable, sync_clr, terminal, increment.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt     <= '0;
        div     <= RST_DIV;
        sh_div  <= RST_DIV;
        mode    <= RST_MODE;
        sh_mode <= RST_MODE;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        pend_q  <= 1'b0;
      end else if (!en[i]) begin
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
        // A direct write is newer than any stale shadow, so it wins.
        if (wr) begin
          div     <= cfg_div;
          mode    <= mode_t'(cfg_mode);
          sh_div  <= cfg_div;
          sh_mode <= mode_t'(cfg_mode);
        end else if (pend_q) begin
          div  <= sh_div;
          mode <= sh_mode;
        end
      end else if (sync_clr) begin
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        if (pend_q) begin
          div  <= sh_div;
          mode <= sh_mode;
        end
        // The old shadow is consumed above before a same-cycle write replaces it.
        if (wr) begin
          sh_div  <= cfg_div;
          sh_mode <= mode_t'(cfg_mode);
          pend_q  <= 1'b1;
        end else begin
          pend_q  <= 1'b0;
        end
      end else if (term) begin
        cnt    <= '0;
        tick_q <= 1'b1;
        if (pend_q) begin
          div  <= sh_div;
          mode <= sh_mode;
          if (sh_mode != mode)          clk_q <= 1'b0;
          else if (sh_mode == MODE_TICK) clk_q <= 1'b1;
          else                          clk_q <= ~clk_q;
        end else begin
          clk_q <= (mode == MODE_TICK) ? 1'b1 : ~clk_q;
        end
        if (wr) begin
          sh_div  <= cfg_div;
          sh_mode <= mode_t'(cfg_mode);
          pend_q  <= 1'b1;
        end else begin
          pend_q  <= 1'b0;
        end
      end else begin
        cnt    <= cnt + CNT_W'(1);
        tick_q <= 1'b0;
        if (mode == MODE_TICK) clk_q <= 1'b0;
        if (wr) begin
          sh_div  <= cfg_div;
          sh_mode <= mode_t'(cfg_mode);
          pend_q  <= 1'b1;
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_freq_div_prog.sv
// Directed testbench for freq_div_prog with three channels.
module tb_freq_div_prog;

  localparam int CNT_W = 26;
  localparam int NCH   = 3;
  localparam int CHW   = 2;

  logic             clk;
  logic             rst_n;
  logic [NCH-1:0]   en;
  logic             sync_clr;
  logic             cfg_we;
  logic [CHW-1:0]   cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_mode;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pending;

  int checks;
  int errors;

  freq_div_prog #(
    .CNT_W   (CNT_W),
    .NUM_CH  (NCH),
    .CH_W    (CHW),
    .DEF_DIV (20000),
    .DEF_MODE(0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sync_clr(sync_clr),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_mode(cfg_mode),
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a config write for exactly one edge.
  task automatic cfg_write(input int ch, input int dv, input bit md);
    cfg_we   = 1'b1;
    cfg_ch   = CHW'(ch);
    cfg_div  = CNT_W'(dv);
    cfg_mode = md;
    step(1);
    cfg_we   = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL reset_clk_out got %b exp %b", clk_out, 3'b000); end
    checks++; if (tick    !== 3'b000) begin errors++; $display("FAIL reset_tick got %b exp %b", tick, 3'b000); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending got %b exp %b", pending, 3'b000); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_default_div;
    en = 3'b001;
    step(20000);
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL def_before_rise got %b exp %b", clk_out, 3'b000); end
    step(1);
    checks++; if (clk_out !== 3'b001) begin errors++; $display("FAIL def_rise got %b exp %b", clk_out, 3'b001); end
    checks++; if (tick    !== 3'b001) begin errors++; $display("FAIL def_tick got %b exp %b", tick, 3'b001); end
    step(1);
    checks++; if (tick    !== 3'b000) begin errors++; $display("FAIL def_tick_one_cycle got %b exp %b", tick, 3'b000); end
    step(19999);
    checks++; if (clk_out !== 3'b001) begin errors++; $display("FAIL def_before_fall got %b exp %b", clk_out, 3'b001); end
    step(1);
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL def_fall got %b exp %b", clk_out, 3'b000); end
    en = 3'b000;
    step(1);
  endtask

  task automatic test_runtime_load;
    cfg_write(1, 4, 1'b0);
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL load_disabled_pending got %b exp %b", pending, 3'b000); end
    en = 3'b010;
    step(2);
    cfg_write(1, 9, 1'b0);
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL load_pending_set got %b exp %b", pending, 3'b010); end
    step(1);
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL load_pending_hold got %b exp %b", pending, 3'b010); end
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL load_before_term got %b exp %b", clk_out, 3'b000); end
    step(1);
    checks++; if (clk_out !== 3'b010) begin errors++; $display("FAIL load_term_toggle got %b exp %b", clk_out, 3'b010); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL load_pending_clear got %b exp %b", pending, 3'b000); end
    step(9);
    checks++; if (clk_out !== 3'b010) begin errors++; $display("FAIL load_new_half_hold got %b exp %b", clk_out, 3'b010); end
    step(1);
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL load_new_half_end got %b exp %b", clk_out, 3'b000); end
    en = 3'b000;
    step(1);
  endtask

  task automatic test_tick_mode;
    cfg_write(2, 3, 1'b1);
    en = 3'b100;
    step(3);
    checks++; if (tick    !== 3'b000) begin errors++; $display("FAIL tickm_idle_tick got %b exp %b", tick, 3'b000); end
    step(1);
    checks++; if (tick    !== 3'b100) begin errors++; $display("FAIL tickm_pulse got %b exp %b", tick, 3'b100); end
    checks++; if (clk_out !== 3'b100) begin errors++; $display("FAIL tickm_clk_mirror got %b exp %b", clk_out, 3'b100); end
    step(1);
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL tickm_clk_low got %b exp %b", clk_out, 3'b000); end
    step(3);
    checks++; if (tick    !== 3'b100) begin errors++; $display("FAIL tickm_second_pulse got %b exp %b", tick, 3'b100); end
    en = 3'b000;
    step(1);
    cfg_write(2, 0, 1'b1);
    en = 3'b100;
    for (int k = 0; k < 3; k++) begin
      step(1);
      checks++; if (tick !== 3'b100) begin errors++; $display("FAIL div0_tick_high cyc %0d got %b exp %b", k, tick, 3'b100); end
    end
    en = 3'b000;
    step(1);
  endtask

  task automatic test_boundary;
    // write coincident with terminal edge
    cfg_write(1, 4, 1'b0);
    en = 3'b010;
    step(4);
    cfg_write(1, 2, 1'b0);
    checks++; if (clk_out !== 3'b010) begin errors++; $display("FAIL coinc_term_toggle got %b exp %b", clk_out, 3'b010); end
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL coinc_pending got %b exp %b", pending, 3'b010); end
    step(4);
    checks++; if (clk_out !== 3'b010) begin errors++; $display("FAIL coinc_old_div_used got %b exp %b", clk_out, 3'b010); end
    step(1);
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL coinc_second_toggle got %b exp %b", clk_out, 3'b000); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL coinc_pending_clear got %b exp %b", pending, 3'b000); end
    step(2);
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL coinc_new_before got %b exp %b", clk_out, 3'b000); end
    step(1);
    checks++; if (clk_out !== 3'b010) begin errors++; $display("FAIL coinc_new_div got %b exp %b", clk_out, 3'b010); end
    en = 3'b000;
    step(1);
    // two writes before terminal, last wins
    cfg_write(1, 4, 1'b0);
    en = 3'b010;
    step(1);
    cfg_write(1, 7, 1'b0);
    cfg_write(1, 2, 1'b0);
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL dbl_pending got %b exp %b", pending, 3'b010); end
    step(2);
    checks++; if (clk_out !== 3'b010) begin errors++; $display("FAIL dbl_first_toggle got %b exp %b", clk_out, 3'b010); end
    step(2);
    checks++; if (clk_out !== 3'b010) begin errors++; $display("FAIL dbl_hold got %b exp %b", clk_out, 3'b010); end
    step(1);
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL dbl_last_wins got %b exp %b", clk_out, 3'b000); end
    en = 3'b000;
    step(1);
    // out-of-range channel is ignored
    cfg_write(1, 4, 1'b0);
    cfg_write(3, 1, 1'b0);
    en = 3'b010;
    cfg_write(3, 1, 1'b0);
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL oor_pending got %b exp %b", pending, 3'b000); end
    step(3);
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL oor_before got %b exp %b", clk_out, 3'b000); end
    step(1);
    checks++; if (clk_out !== 3'b010) begin errors++; $display("FAIL oor_div_kept got %b exp %b", clk_out, 3'b010); end
    en = 3'b000;
    step(1);
  endtask

  task automatic test_sync_clr;
    cfg_write(0, 5, 1'b0);
    cfg_write(1, 3, 1'b0);
    en = 3'b001;
    step(3);
    en = 3'b011;
    step(10);
    cfg_write(1, 7, 1'b0);
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL sync_pre_pending got %b exp %b", pending, 3'b010); end
    sync_clr = 1'b1;
    cfg_write(0, 5, 1'b0);
    sync_clr = 1'b0;
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL sync_clk_clear got %b exp %b", clk_out, 3'b000); end
    checks++; if (tick    !== 3'b000) begin errors++; $display("FAIL sync_tick_clear got %b exp %b", tick, 3'b000); end
    checks++; if (pending !== 3'b001) begin errors++; $display("FAIL sync_pending got %b exp %b", pending, 3'b001); end
    step(5);
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL sync_before got %b exp %b", clk_out, 3'b000); end
    step(1);
    checks++; if (clk_out !== 3'b001) begin errors++; $display("FAIL sync_ch0_6 got %b exp %b", clk_out, 3'b001); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL sync_ch0_apply got %b exp %b", pending, 3'b000); end
    step(1);
    checks++; if (clk_out !== 3'b001) begin errors++; $display("FAIL sync_ch1_7 got %b exp %b", clk_out, 3'b001); end
    step(1);
    checks++; if (clk_out !== 3'b011) begin errors++; $display("FAIL sync_ch1_8 got %b exp %b", clk_out, 3'b011); end
    en = 3'b000;
    step(1);
  endtask

  task automatic test_mid_reset;
    cfg_write(1, 4, 1'b0);
    en = 3'b010;
    step(5);
    checks++; if (clk_out !== 3'b010) begin errors++; $display("FAIL mrst_pre_clk got %b exp %b", clk_out, 3'b010); end
    cfg_write(1, 9, 1'b0);
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL mrst_pre_pending got %b exp %b", pending, 3'b010); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL mrst_async_clk got %b exp %b", clk_out, 3'b000); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL mrst_async_pending got %b exp %b", pending, 3'b000); end
    #1;
    rst_n = 1'b1;
    step(5);
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL mrst_div_not_4 got %b exp %b", clk_out, 3'b000); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL mrst_pending_after got %b exp %b", pending, 3'b000); end
    step(19995);
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL mrst_before_rise got %b exp %b", clk_out, 3'b000); end
    step(1);
    checks++; if (clk_out !== 3'b010) begin errors++; $display("FAIL mrst_def_div got %b exp %b", clk_out, 3'b010); end
    en = 3'b000;
    step(1);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    en       = '0;
    sync_clr = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_div  = '0;
    cfg_mode = 1'b0;
    test_reset;
    test_default_div;
    test_runtime_load;
    test_tick_mode;
    test_boundary;
    test_sync_clr;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_div_prog.md
Name: freq_div_prog

Overview:
- Multi-channel programmable clock divider. It replaces fixed single-divisor dividers such as the 100 Hz divider.
- Each channel has a runtime-loadable divisor and a mode:
  - square mode: 50% duty divided clock.
  - tick mode: one-cycle enable pulse.
- Divisor and mode updates are glitch-free because they are buffered in a shadow register and applied at the channel's terminal count.
- The block sits beside the board clock and feeds the display scan, debounce and counter blocks.

Parameters:
CNT_W, 26, counter and divisor width in bits
NUM_CH, 4, number of independent channels (1..16)
CH_W, 2, width of cfg_ch; must satisfy 2**CH_W >= NUM_CH
DEF_DIV, 20000, divisor loaded into every channel at reset
DEF_MODE, 0, mode loaded at reset (0 = square, 1 = tick)

Ports:
clk  input  1  global clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  NUM_CH  per-channel run enable, level
sync_clr  input  1  one-cycle pulse; phase-aligns all channels
cfg_we  input  1  configuration write strobe, one cycle
cfg_ch  input  CH_W  target channel of the write
cfg_div  input  CNT_W  new divisor
cfg_mode  input  1  new mode (0 square, 1 tick)
clk_out  output  NUM_CH  divided output per channel (registered)
tick  output  NUM_CH  one-cycle terminal-count pulse per channel (registered)
pending  output  NUM_CH  shadow config waiting to be applied

Behaviour:
- Reset (rst_n low, asynchronous):
  - all cnt = 0; active div = DEF_DIV; mode = DEF_MODE; shadows = DEF_DIV/DEF_MODE.
  - clk_out = 0, tick = 0, pending = 0.
- Per-channel counter, enabled:
  - cnt counts 0..div.
  - Terminal condition is cnt == div.
  - At the terminal edge: cnt <= 0 and tick <= 1 for exactly one cycle. Otherwise cnt <= cnt + 1 (wraps mod 2**CNT_W; unreachable when div is valid).
- Square mode: clk_out toggles at each terminal edge, giving a period of 2*(div+1) clk cycles.
- Tick mode: clk_out mirrors tick, high 1 cycle out of every div+1.
- div = 0: terminal every cycle.
  - tick is held continuously high.
  - square mode gives clk/2.
- Disabled (en[i] = 0):
  - cnt <= 0, clk_out <= 0, tick <= 0.
  - Any pending shadow is applied on the next edge and pending clears.
- Re-enable: counting restarts from 0; first terminal edge occurs div+1 cycles after en rises.
- Config write (cfg_we = 1):
  - cfg_ch >= NUM_CH: the write is ignored.
  - Target channel disabled: active div/mode update on the next edge; pending stays 0.
  - Target channel enabled: shadow <= {cfg_div, cfg_mode} and pending <= 1. The shadow is applied at that channel's next terminal edge, and pending clears on that edge.
  - The new div governs the count that starts after the terminal edge.
  - A write in the same cycle as a terminal edge is not applied on that edge; it waits for the following terminal edge.
  - A second write while pending overwrites the shadow; the last write wins.
  - When an apply changes the mode, clk_out <= 0 on the apply edge. tick still pulses on that edge.
- sync_clr = 1 (priority over terminal count and config apply ordering):
  - on the next edge, every channel has cnt <= 0, clk_out <= 0, tick <= 0.
  - all pending shadows are applied and pending clears.
  - A cfg_we in the same cycle as sync_clr goes to the shadow and stays pending.
- Priority per channel, highest first: rst_n, en low, sync_clr, terminal count, increment.
- All outputs are registered with no combinational path from inputs. Latency from any input event to an output change is 1 edge.

Test Plan:
- Reset default, en=0001, DEF_DIV=20000: clk_out[0] first rises 20001 cycles after en; period 40002 cycles; other channels stay 0.
- Runtime load: ch1 enabled with div=4, square mode. Write div=9 at cnt=2. pending[1]=1 until the terminal edge of the cnt==4 count; the next half-period is 10 cycles.
- Tick mode: ch2, div=3, mode=1. tick[2] and clk_out[2] are high 1 cycle in every 4. div=0 gives tick constantly high.
- Boundary cases:
  - a write coincident with the terminal edge applies one period later.
  - two writes before terminal: the second value is used.
  - cfg_ch=3 with NUM_CH=3 is ignored.
- sync_clr: channels with div 5 and 7 are out of phase. After a sync_clr pulse, both clk_out are 0 and first toggles occur 6 and 8 cycles later.
- Mid-operation reset: assert rst_n low asynchronously mid-period. Outputs clear immediately without waiting for clk; after release, div returns to DEF_DIV and pending=0.
